// File: rtl/ysyx_22040895_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package ysyx_22040895_mdu_pkg;

  localparam int MDU_XLEN = 64;

  typedef enum logic [3:0] {
    MDU_NONE   = 4'd0,
    MDU_MUL    = 4'd1,
    MDU_MULH   = 4'd2,
    MDU_MULHSU = 4'd3,
    MDU_MULHU  = 4'd4,
    MDU_DIV    = 4'd5,
    MDU_DIVU   = 4'd6,
    MDU_REM    = 4'd7,
    MDU_REMU   = 4'd8
  } mduop_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/ysyx_22040895_mdu_iter.sv
// One-bit-per-cycle datapath: left-shift shift-add multiply and restoring
// divide on unsigned magnitudes. Word ops run XLEN/2 steps; the dividend is
// pre-aligned to the top of the quotient register so both widths share the
// same step logic.
module ysyx_22040895_mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic              wordop,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  output logic              last,
  output logic [2*XLEN-1:0] acc
);

  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  logic [2*XLEN-1:0] mcand;   // shifted multiplicand (MUL only)
  logic [XLEN-1:0]   mplier;  // multiplier for MUL, divisor for DIV
  logic [CW-1:0]     cnt;
  logic              div_q;
  logic              word_q;

  // Restoring step: bring next dividend bit into the partial remainder.
  logic [XLEN:0]     trial;
  logic              fits;
  logic [XLEN-1:0]   rem_sub;

  assign trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign fits    = (trial >= {1'b0, mplier});
  // When fits, trial - divisor < divisor, so the low XLEN bits are exact.
  assign rem_sub = trial[XLEN-1:0] - mplier;
  assign last    = (cnt == CW'(word_q ? H - 1 : XLEN - 1));

  // Load operands on accept, then advance one bit per enabled step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      div_q  <= 1'b0;
      word_q <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      div_q  <= is_div;
      word_q <= wordop;
      mplier <= opb;
      if (is_div) begin
        acc   <= {{XLEN{1'b0}}, (wordop ? {opa[H-1:0], {H{1'b0}}} : opa)};
        mcand <= '0;
      end else begin
        acc   <= '0;
        mcand <= {{XLEN{1'b0}}, opa};
      end
    end else if (step) begin
      cnt <= cnt + CW'(1);
      if (div_q) begin
        acc <= {(fits ? rem_sub : trial[XLEN-1:0]), acc[XLEN-2:0], fits};
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22040895_mdu_ctrl.sv
// Iterative RV64M sequencer: operand preprocessing, corner-case short-cuts,
// FSM, sign fix-up and valid/ready handshakes around the iter datapath.
// Latency is counted in clock edges including the accept edge: short-cut ops
// present the result right after the accept edge (1), iterating ops after
// N steps + FIX (N+2).
module ysyx_22040895_mdu_ctrl
  import ysyx_22040895_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      mduop_i,
  input  logic            wordop_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int H = XLEN / 2;

  state_e          state, state_nxt;
  mduop_e          op_q;
  logic            word_q;
  logic            neg_q;
  logic [XLEN-1:0] result_q;

  // ---- request decode -------------------------------------------------
  mduop_e          op_in;
  logic            legal, accept;
  logic            is_div_in, is_rem_in, a_sgn, b_sgn;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  logic            a_neg, b_neg;
  logic            div_zero, ovf, shortcut;
  logic [XLEN-1:0] sc_raw, sc_val;
  logic            neg_in;

  assign op_in     = mduop_e'(mduop_i);
  assign legal     = (mduop_i >= 4'd1) && (mduop_i <= 4'd8);
  assign accept    = in_valid_i && in_ready_o && legal && !flush_i;
  assign is_div_in = op_in inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  assign is_rem_in = op_in inside {MDU_REM, MDU_REMU};
  assign a_sgn     = op_in inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  assign b_sgn     = op_in inside {MDU_MULH, MDU_DIV, MDU_REM};

  assign a_ext = wordop_i ? {{H{a_sgn & op1_i[H-1]}}, op1_i[H-1:0]} : op1_i;
  assign b_ext = wordop_i ? {{H{b_sgn & op2_i[H-1]}}, op2_i[H-1:0]} : op2_i;
  assign a_neg = a_sgn & a_ext[XLEN-1];
  assign b_neg = b_sgn & b_ext[XLEN-1];
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  // Remainder follows the dividend sign; products and quotients the xor.
  assign neg_in = is_rem_in ? a_neg : (a_neg ^ b_neg);

  assign div_zero = is_div_in && (b_ext == '0);
  assign ovf      = (op_in inside {MDU_DIV, MDU_REM}) && (b_ext == '1) &&
                    (a_ext == (wordop_i ? {{(H+1){1'b1}}, {(H-1){1'b0}}}
                                        : {1'b1, {(XLEN-1){1'b0}}}));
  assign shortcut = div_zero || ovf;

  assign sc_raw = div_zero ? (is_rem_in ? a_ext : '1)
                           : (is_rem_in ? '0 : a_ext);
  assign sc_val = wordop_i ? {{H{sc_raw[H-1]}}, sc_raw[H-1:0]} : sc_raw;

  // ---- iteration datapath ---------------------------------------------
  logic              step, last;
  logic [2*XLEN-1:0] acc;

  assign step = ((state == S_MUL) || (state == S_DIV)) && !flush_i;

  ysyx_22040895_mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (step),
    .is_div (is_div_in),
    .wordop (wordop_i),
    .opa    (a_mag),
    .opb    (b_mag),
    .last   (last),
    .acc    (acc)
  );

  // ---- sign fix-up and result select ------------------------------------
  logic              is_div_q, is_rem_q;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_val, div_raw, div_s, fix_raw, fix_val;

  assign is_div_q = op_q inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  assign is_rem_q = op_q inside {MDU_REM, MDU_REMU};
  assign prod_s   = neg_q ? -acc : acc;
  // Word products are 2*H = XLEN bits wide, so MULH* takes bits [XLEN-1:H].
  assign mul_val  = (op_q == MDU_MUL) ? prod_s[XLEN-1:0]
                  : (word_q ? {{H{1'b0}}, prod_s[XLEN-1:H]} : prod_s[2*XLEN-1:XLEN]);
  assign div_raw  = is_rem_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign div_s    = neg_q ? -div_raw : div_raw;
  assign fix_raw  = is_div_q ? div_s : mul_val;
  assign fix_val  = word_q ? {{H{fix_raw[H-1]}}, fix_raw[H-1:0]} : fix_raw;

  // ---- FSM ----------------------------------------------------------------
  // State register plus latched op attributes and the presented result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      op_q     <= MDU_NONE;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= op_in;
        word_q <= wordop_i;
        neg_q  <= neg_in;
        if (shortcut) result_q <= sc_val;
      end
      if ((state == S_FIX) && !flush_i) result_q <= fix_val;
    end
  end

  // Next-state: flush beats everything outside IDLE, including out_ready_i.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (accept) state_nxt = shortcut ? S_DONE : (is_div_in ? S_DIV : S_MUL);
      S_MUL, S_DIV: if (flush_i) state_nxt = S_IDLE;
                    else if (last) state_nxt = S_FIX;
      S_FIX:        state_nxt = flush_i ? S_IDLE : S_DONE;
      S_DONE:       if (flush_i || out_ready_i) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state == S_IDLE);
  assign out_valid_o = (state == S_DONE);
  assign busy_o      = (state != S_IDLE);
  assign result_o    = result_q;

endmodule

// File: doc/ysyx_22040895_mdu_ctrl.md
Name: ysyx_22040895_mdu_ctrl

Overview:
Iterative multiply/divide sequencer for the execute stage. It replaces the single-cycle combinational MDU path and runs RV64M/RV64M-W operations radix-2, one bit per cycle. Operands arrive on a valid/ready handshake from EXU issue, and the block holds the pipeline stall (busy_o) until the result is consumed. It handles every RISC-V M-extension corner case (divide by zero, signed overflow) without iterating.

Parameters:
XLEN, 64, datapath width; word ops use XLEN/2.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-low reset
flush_i  input  1  cancel any in-flight op (branch/trap redirect)
in_valid_i  input  1  operation request
in_ready_o  output  1  block can accept a request
mduop_i  input  4  operation code (package encoding)
wordop_i  input  1  W-variant: use op[31:0], sign-extend the 32-bit result
op1_i  input  XLEN  rs1 value
op2_i  input  XLEN  rs2 value
out_valid_o  output  1  result_o valid
out_ready_i  input  1  consumer accepts the result
result_o  output  XLEN  final result
busy_o  output  1  stall request to the pipeline; high from accept until the result handshake

Behaviour:
- mduop encoding: 0 none; 1 MUL; 2 MULH; 3 MULHSU; 4 MULHU; 5 DIV; 6 DIVU; 7 REM; 8 REMU; 9-15 illegal, treated as none (never accepted).
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Reset (rst low, async): state=IDLE; out_valid_o=0, busy_o=0, result_o=0, in_ready_o=1 after release; all iteration counters and accumulators cleared.
- in_ready_o = (state==IDLE). Accept when in_valid_i & in_ready_o & mduop in 1..8 & !flush_i.
- On accept, latch op/wordop. For word ops, first sign- or zero-extend the operands from bit 31 according to the op signedness.
- Compute N = wordop ? 32 : 64. Take magnitudes of signed operands and record the result and remainder negate flags.
- Short-cut at accept: the next state is DONE with result already formed, with no iteration, in these cases:
  - divisor==0: DIV/DIVU give all ones; REM/REMU give the dividend (each truncated and sign-extended for W).
  - signed overflow (dividend = most-negative of width N, divisor = -1): DIV gives the dividend; REM gives 0.
- MUL state: shift-add over a 2N-bit product register, one multiplier bit per cycle, N cycles.
- DIV state: restoring division over 2N-bit remainder:quotient, N cycles.
- FIX state, 1 cycle: apply the negate flags. Select low half (MUL) or high half (MULH*), quotient or remainder. For W ops, sign-extend bit 31.
- DONE: out_valid_o=1 and result_o stable; hold both until out_ready_i. On the handshake go to IDLE, clear out_valid_o and busy_o in the same edge.
- Latency from the accept edge to out_valid_o high: N+2 cycles for iterating ops (64-bit op: 66; W op: 34); 1 cycle for short-cut ops.
- busy_o=1 in MUL, DIV, FIX and DONE.
- flush_i in any non-IDLE state: next edge goes to IDLE, clears out_valid_o and busy_o, and discards the result. flush_i wins over a simultaneous out_ready_i. A flush in IDLE blocks acceptance in that cycle.
- A back-to-back request is accepted at the earliest in the cycle after the DONE handshake, since in_ready_o is only high in IDLE.
- Async reset mid-operation aborts immediately. No partial result is ever presented.

Decomposition:
- Shared package/define file: mduop codes, FSM state encodings, XLEN.
- One natural sub-module: ysyx_22040895_mdu_iter. It holds the shift-add / restoring-divide step datapath (accumulator, shift register, counter).
- ysyx_22040895_mdu_ctrl keeps the FSM, operand preprocessing, corner-case detection, sign fix-up and handshakes.

Test Plan:
- MUL 3 x 0xFFFF_FFFF_FFFF_FFFB (-5) -> result 0xFFFF_FFFF_FFFF_FFF1; out_valid_o exactly 66 cycles after accept; busy_o high throughout.
- MULHU 0xFFFF_FFFF_FFFF_FFFF x same -> 0xFFFF_FFFF_FFFF_FFFE. MULH on the same operands -> 0.
- DIVU 100/0 -> 0xFFFF_FFFF_FFFF_FFFF and REMU 100/0 -> 100, each valid 1 cycle after accept. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM of the same -> 0.
- DIV (W) with op1=0x0000_0000_8000_0000, op2=-1 -> 0xFFFF_FFFF_8000_0000 (overflow short-cut). REMW of -7 by 2 -> 0xFFFF_FFFF_FFFF_FFFF; this one iterates, valid at cycle 34.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o rises -> result_o stable and in_ready_o=0; then assert out_ready_i -> in_ready_o=1 on the next cycle.
- Assert flush_i at iteration 20 of a DIV, and separately pull rst low at iteration 5 of a MUL -> IDLE, out_valid_o never pulses. A new MUL 6x7 then returns 42.
